// File: rtl/async_fifo_pkg.sv
// Shared definitions for the async FIFO read-side packer: width defaults,
// packer state names and the fill-counter width helper.
package async_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_PACK_RATIO = 4;

  // ACCUM      : collecting lanes, no flush pending
  // FULL_WAIT  : all lanes stored, output slot still occupied
  // FLUSH_WAIT : flush latched, waiting for in-flight data and a free slot
  typedef enum logic [1:0] {
    ACCUM      = 2'd0,
    FULL_WAIT  = 2'd1,
    FLUSH_WAIT = 2'd2
  } pack_state_e;

  // Width needed to count 0..pack_ratio stored lanes.
  function automatic int fill_w(input int pack_ratio);
    return $clog2(pack_ratio + 1);
  endfunction

  localparam int FILL_W = fill_w(DEF_PACK_RATIO);

endpackage

// File: rtl/fifo_rd_packer.sv
// Read-side consumer of the async FIFO. Pops DATA_WIDTH entries and packs
// PACK_RATIO of them into one word on a valid/ready stream; a flush emits the
// partial word with a lane-keep mask and a last marker.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ACCUM      | fill < PACK_RATIO, popping entries into lanes
// FULL_WAIT  | fill == PACK_RATIO, word parked until the output slot frees
// FLUSH_WAIT | flush latched; no new pops until the partial word is emitted
module fifo_rd_packer
  import async_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PACK_RATIO = DEF_PACK_RATIO
) (
  input  logic                             rd_clk,
  input  logic                             rd_rst,
  input  logic                             fifo_empty,
  input  logic [DATA_WIDTH-1:0]            data_out,
  output logic                             rd_en,
  input  logic                             flush,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] m_data,
  output logic [PACK_RATIO-1:0]            m_keep,
  output logic                             m_last,
  output logic                             m_valid,
  input  logic                             m_ready
);

  localparam int FW = fill_w(PACK_RATIO);
  localparam int CW = FW + 1;
  localparam logic [CW-1:0] PR_C = CW'(PACK_RATIO);

  logic [FW-1:0]                     r_fill;
  logic                              r_inflight;
  logic                              r_flush_pend;
  logic [DATA_WIDTH-1:0]             r_lane [PACK_RATIO];
  logic [DATA_WIDTH*PACK_RATIO-1:0]  r_m_data;
  logic [PACK_RATIO-1:0]             r_m_keep;
  logic                              r_m_last;
  logic                              r_m_valid;

  pack_state_e                       w_state;
  logic [CW-1:0]                     w_fill_land;
  logic                              w_slot_free;
  logic                              w_full;
  logic                              w_emit_full;
  logic                              w_flush_go;
  logic                              w_emit_part;
  logic                              w_last_full;
  logic [DATA_WIDTH*PACK_RATIO-1:0]  w_word;
  logic [DATA_WIDTH*PACK_RATIO-1:0]  w_part_data;
  logic [PACK_RATIO-1:0]             w_part_keep;

  // Lane count including the entry landing this cycle.
  assign w_fill_land = {1'b0, r_fill} + CW'(r_inflight);
  assign w_slot_free = !r_m_valid || m_ready;
  assign w_full      = (w_fill_land == PR_C);
  assign w_emit_full = w_full && w_slot_free;
  // A full word parked behind a pending flush is closed by w_emit_full, not here.
  assign w_flush_go  = r_flush_pend && !r_inflight && w_slot_free && !w_full;
  assign w_emit_part = w_flush_go && (r_fill != '0);
  // A flush arriving together with the completing lane closes that word.
  assign w_last_full = r_flush_pend || flush;

  // Implicit state decode from the fill counter and the flush latch.
  always_comb begin
    w_state = ACCUM;
    if (r_flush_pend) begin
      w_state = FLUSH_WAIT;
    end else if ({1'b0, r_fill} == PR_C) begin
      w_state = FULL_WAIT;
    end
  end

  // Pop only while accumulating and a lane is free for the returning entry.
  assign rd_en = !rd_rst && !fifo_empty && (w_state == ACCUM) && (w_fill_land < PR_C);

  // Assemble the outgoing word, substituting the landing entry into its lane.
  always_comb begin
    w_word      = '0;
    w_part_data = '0;
    w_part_keep = '0;
    for (int i = 0; i < PACK_RATIO; i++) begin
      if (r_inflight && (r_fill == FW'(i))) begin
        w_word[i*DATA_WIDTH +: DATA_WIDTH] = data_out;
      end else begin
        w_word[i*DATA_WIDTH +: DATA_WIDTH] = r_lane[i];
      end
      w_part_keep[i] = (CW'(i) < w_fill_land);
      if (w_part_keep[i]) begin
        w_part_data[i*DATA_WIDTH +: DATA_WIDTH] = w_word[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Lane accumulator: write-enable decoded from fill when an entry lands.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      for (int i = 0; i < PACK_RATIO; i++) begin
        r_lane[i] <= '0;
      end
    end else begin
      for (int i = 0; i < PACK_RATIO; i++) begin
        if (r_inflight && (r_fill == FW'(i))) begin
          r_lane[i] <= data_out;
        end
      end
    end
  end

  // Fill counter, in-flight tracker and flush latch.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      r_fill       <= '0;
      r_inflight   <= 1'b0;
      r_flush_pend <= 1'b0;
    end else begin
      r_inflight <= rd_en;
      if (w_emit_full || w_flush_go) begin
        r_fill       <= '0;
        r_flush_pend <= 1'b0;
      end else begin
        r_fill <= w_fill_land[FW-1:0];
        if (flush) begin
          r_flush_pend <= 1'b1;
        end
      end
    end
  end

  // Output slot: load on completion or flush, drop valid only after a transfer.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      r_m_data  <= '0;
      r_m_keep  <= '0;
      r_m_last  <= 1'b0;
      r_m_valid <= 1'b0;
    end else if (w_emit_full) begin
      r_m_data  <= w_word;
      r_m_keep  <= '1;
      r_m_last  <= w_last_full;
      r_m_valid <= 1'b1;
    end else if (w_emit_part) begin
      r_m_data  <= w_part_data;
      r_m_keep  <= w_part_keep;
      r_m_last  <= 1'b1;
      r_m_valid <= 1'b1;
    end else if (r_m_valid && m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

  assign m_data  = r_m_data;
  assign m_keep  = r_m_keep;
  assign m_last  = r_m_last;
  assign m_valid = r_m_valid;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer: per-cycle vector table for streaming and
// backpressure, hand-written sequences for flush and mid-word reset.
module tb_fifo_rd_packer;

  logic        rd_clk;
  logic        rd_rst;
  logic        fifo_empty;
  logic [7:0]  data_out;
  logic        rd_en;
  logic        flush;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_last;
  logic        m_valid;
  logic        m_ready;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] q[$];

  typedef struct {
    logic        push;
    logic [7:0]  pval;
    logic        ready;
    logic        fl;
    logic        e_rd;
    logic        e_valid;
    logic [31:0] e_data;
    logic [3:0]  e_keep;
    logic        e_last;
  } vec_t;

  vec_t vecs [31];

  fifo_rd_packer #(.DATA_WIDTH(8), .PACK_RATIO(4)) dut (
    .rd_clk    (rd_clk),
    .rd_rst    (rd_rst),
    .fifo_empty(fifo_empty),
    .data_out  (data_out),
    .rd_en     (rd_en),
    .flush     (flush),
    .m_data    (m_data),
    .m_keep    (m_keep),
    .m_last    (m_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready)
  );

  initial begin
    rd_clk = 1'b0;
    forever #5 rd_clk = ~rd_clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] v);
    q.push_back(v);
    fifo_empty = 1'b0;
  endtask

  // Advance one clock; the FIFO model returns data the edge after rd_en.
  task automatic tick();
    logic popped;
    popped = rd_en;
    @(posedge rd_clk);
    #1;
    if (popped) begin
      if (q.size() > 0) begin
        data_out = q.pop_front();
      end else begin
        chk("fifo underflow", 32'd1, 32'd0);
      end
    end
    fifo_empty = (q.size() == 0);
    @(negedge rd_clk);
  endtask

  task automatic run_cycle(input string tag, input logic e_rd, input logic e_valid,
                           input logic [31:0] e_data, input logic [3:0] e_keep,
                           input logic e_last);
    #1;
    chk($sformatf("%s rd_en", tag), {31'd0, rd_en}, {31'd0, e_rd});
    chk($sformatf("%s m_valid", tag), {31'd0, m_valid}, {31'd0, e_valid});
    if (e_valid) begin
      chk($sformatf("%s m_data", tag), m_data, e_data);
      chk($sformatf("%s m_keep", tag), {28'd0, m_keep}, {28'd0, e_keep});
      chk($sformatf("%s m_last", tag), {31'd0, m_last}, {31'd0, e_last});
    end
    tick();
  endtask

  initial begin
    // Streaming rows 0..11, backpressure rows 12..30.
    //             push  pval   rdy  fl  rd  vld  data          keep  last
    vecs[0]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0};
    vecs[1]  = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0};
    vecs[2]  = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0};
    vecs[3]  = '{1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0};
    vecs[4]  = '{1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
    vecs[5]  = '{1'b1, 8'h66, 1'b1, 1'b0, 1'b1, 1'b1, 32'h44332211, 4'hF, 1'b0};
    vecs[6]  = '{1'b1, 8'h77, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0};
    vecs[7]  = '{1'b1, 8'h88, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 32'h88776655, 4'hF, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
    vecs[12] = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0};
    vecs[13] = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0};
    vecs[14] = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0};
    vecs[15] = '{1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0};
    vecs[16] = '{1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
    vecs[17] = '{1'b1, 8'h66, 1'b0, 1'b0, 1'b1, 1'b1, 32'h44332211, 4'hF, 1'b0};
    vecs[18] = '{1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b1, 32'h44332211, 4'hF, 1'b0};
    vecs[19] = '{1'b1, 8'h88, 1'b0, 1'b0, 1'b1, 1'b1, 32'h44332211, 4'hF, 1'b0};
    vecs[20] = '{1'b1, 8'h99, 1'b0, 1'b0, 1'b1, 1'b1, 32'h44332211, 4'hF, 1'b0};
    vecs[21] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 32'h44332211, 4'hF, 1'b0};
    vecs[22] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 32'h44332211, 4'hF, 1'b0};
    vecs[23] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 32'h44332211, 4'hF, 1'b0};
    vecs[24] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 32'h44332211, 4'hF, 1'b0};
    vecs[25] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 32'h88776655, 4'hF, 1'b0};
    vecs[26] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
    vecs[27] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
    vecs[28] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
    vecs[29] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00000099, 4'h1, 1'b1};
    vecs[30] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};

    rd_rst     = 1'b1;
    fifo_empty = 1'b1;
    data_out   = 8'h00;
    flush      = 1'b0;
    m_ready    = 1'b1;
    push(8'h11);

    // Reset with a non-empty FIFO: everything quiet.
    @(negedge rd_clk);
    #1;
    chk("reset rd_en", {31'd0, rd_en}, 32'd0);
    chk("reset m_valid", {31'd0, m_valid}, 32'd0);
    chk("reset m_data", m_data, 32'd0);
    chk("reset m_keep", {28'd0, m_keep}, 32'd0);
    @(negedge rd_clk);
    rd_rst = 1'b0;

    for (int i = 0; i < 31; i++) begin
      if (vecs[i].push) push(vecs[i].pval);
      m_ready = vecs[i].ready;
      flush   = vecs[i].fl;
      run_cycle($sformatf("vec%0d", i), vecs[i].e_rd, vecs[i].e_valid,
                vecs[i].e_data, vecs[i].e_keep, vecs[i].e_last);
    end
    flush   = 1'b0;
    m_ready = 1'b1;

    // Partial flush of three lanes, then a full word proves fill restarted at 0.
    push(8'hA1); push(8'hA2); push(8'hA3);
    run_cycle("pf0", 1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
    run_cycle("pf1", 1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
    run_cycle("pf2", 1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
    run_cycle("pf3", 1'b0, 1'b0, 32'h0, 4'h0, 1'b0);
    flush = 1'b1;
    run_cycle("pf4", 1'b0, 1'b0, 32'h0, 4'h0, 1'b0);
    flush = 1'b0;
    push(8'hD1);
    run_cycle("pf5 pending", 1'b0, 1'b0, 32'h0, 4'h0, 1'b0);
    push(8'hD2); push(8'hD3); push(8'hD4);
    run_cycle("pf6 word", 1'b1, 1'b1, 32'h00A3A2A1, 4'h7, 1'b1);
    run_cycle("pf7", 1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
    run_cycle("pf8", 1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
    run_cycle("pf9", 1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
    run_cycle("pf10", 1'b0, 1'b0, 32'h0, 4'h0, 1'b0);
    run_cycle("pf11 word", 1'b0, 1'b1, 32'hD4D3D2D1, 4'hF, 1'b0);

    // Flush on the cycle 0xB2 lands with fill=1: the landing lane is included.
    push(8'hB1); push(8'hB2);
    run_cycle("fi0", 1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
    run_cycle("fi1", 1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
    flush = 1'b1;
    run_cycle("fi2", 1'b0, 1'b0, 32'h0, 4'h0, 1'b0);
    flush = 1'b0;
    push(8'hB3);
    run_cycle("fi3 pending", 1'b0, 1'b0, 32'h0, 4'h0, 1'b0);
    run_cycle("fi4 word", 1'b1, 1'b1, 32'h0000B2B1, 4'h3, 1'b1);
    push(8'hB4);
    run_cycle("fi5", 1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
    run_cycle("fi6", 1'b0, 1'b0, 32'h0, 4'h0, 1'b0);

    // Reset mid-word (fill=2) asynchronously, between clock edges.
    push(8'hEE);
    #1;
    chk("pre-reset rd_en", {31'd0, rd_en}, 32'd1);
    #1;
    rd_rst = 1'b1;
    #1;
    chk("async reset rd_en", {31'd0, rd_en}, 32'd0);
    chk("async reset m_valid", {31'd0, m_valid}, 32'd0);
    chk("async reset m_data", m_data, 32'd0);
    chk("async reset m_keep", {28'd0, m_keep}, 32'd0);
    chk("async reset m_last", {31'd0, m_last}, 32'd0);
    q.delete();
    fifo_empty = 1'b1;
    @(negedge rd_clk);
    @(negedge rd_clk);
    rd_rst = 1'b0;
    push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
    run_cycle("rm0", 1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
    run_cycle("rm1", 1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
    run_cycle("rm2", 1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
    run_cycle("rm3", 1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
    run_cycle("rm4", 1'b0, 1'b0, 32'h0, 4'h0, 1'b0);
    run_cycle("rm5 word", 1'b0, 1'b1, 32'hC4C3C2C1, 4'hF, 1'b0);
    run_cycle("rm6", 1'b0, 1'b0, 32'h0, 4'h0, 1'b0);
    run_cycle("rm7", 1'b0, 1'b0, 32'h0, 4'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
